// File: rtl/nmr_bstrm_pkg.sv
// nmr_bstrm_pkg: shared definitions for the NMR bitstream loader/arbiter slice.
//   - loader state encoding (legacy-compatible localparam constants)
//   - WORDS_PER_LINE: host words packed into one program-RAM line
//   - widths_ok(): parameter consistency check used at elaboration
package nmr_bstrm_pkg;

  localparam int unsigned DEF_WORD_WIDTH = 32;
  localparam int unsigned DEF_DAT_WIDTH  = 128;
  localparam int unsigned WORDS_PER_LINE = DEF_DAT_WIDTH / DEF_WORD_WIDTH;

  typedef logic [2:0] loader_state_t;

  localparam loader_state_t ST_IDLE    = 3'd0;
  localparam loader_state_t ST_LOAD    = 3'd1;
  localparam loader_state_t ST_WRITE   = 3'd2;
  localparam loader_state_t ST_READY   = 3'd3;
  localparam loader_state_t ST_START   = 3'd4;
  localparam loader_state_t ST_WAIT_LO = 3'd5;
  localparam loader_state_t ST_WAIT_HI = 3'd6;

  // Line width must hold exactly WORDS_PER_LINE words and be whole bytes.
  function automatic bit widths_ok(input int unsigned word_w, input int unsigned dat_w,
                                   input int unsigned byteen_w);
    return (dat_w == WORDS_PER_LINE * word_w) && (byteen_w * 8 == dat_w);
  endfunction

endpackage

// File: rtl/nmr_bstrm_word_packer.sv
// nmr_bstrm_word_packer: packs host words into program-RAM lines.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   word, accept   host word and its transfer qualifier
//   last           word closes the program (flushes a partial line)
//   line_complete  this accepted word finishes a line (combinational)
//   line           most recently completed line (registered, zero-filled)
module nmr_bstrm_word_packer
  import nmr_bstrm_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned DAT_WIDTH  = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_WIDTH-1:0] word,
  input  logic                  accept,
  input  logic                  last,
  output logic                  line_complete,
  output logic [DAT_WIDTH-1:0]  line
);

  localparam int unsigned CNT_W = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;

  logic [CNT_W-1:0]     cnt_q;
  logic [DAT_WIDTH-1:0] pack_q;
  logic [DAT_WIDTH-1:0] pack_d;
  logic [DAT_WIDTH-1:0] line_q;

  always_comb begin
    line_complete = accept && (last || (cnt_q == CNT_W'(WORDS_PER_LINE - 1)));
    pack_d = pack_q;
    pack_d[cnt_q * WORD_WIDTH +: WORD_WIDTH] = word;
  end

  // pack_q is cleared at each line boundary, so unfilled fields of a partial
  // line come out as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      pack_q <= '0;
      line_q <= '0;
    end else if (accept) begin
      if (line_complete) begin
        line_q <= pack_d;
        pack_q <= '0;
        cnt_q  <= '0;
      end else begin
        pack_q <= pack_d;
        cnt_q  <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign line = line_q;

endmodule

// File: rtl/nmr_bstrm_sram_loader.sv
// nmr_bstrm_sram_loader: loads a pulse program from the host into the program
// RAM (four words per line, from address 0) and launches the arbiter.
// Ports:
//   CLK, RST                      clock, asynchronous active-high reset
//   IN_DAT/IN_VALID/IN_LAST       host word stream, IN_READY back-pressure
//   GO                            run request (honoured only when loaded)
//   ARB_START, ARB_DONE           one-cycle launch pulse, arbiter done level
//   SRAM_*                        program-RAM write port
//   LINES                         lines in the loaded program
//   BUSY                          arbiter run in progress
//   ERR                           sticky program-overflow flag
module nmr_bstrm_sram_loader
  import nmr_bstrm_pkg::*;
#(
  parameter int unsigned WORD_WIDTH        = 32,
  parameter int unsigned SRAM_ADDR_WIDTH   = 8,
  parameter int unsigned SRAM_DAT_WIDTH    = 128,
  parameter int unsigned SRAM_BYTEEN_WIDTH = 16
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [WORD_WIDTH-1:0]        IN_DAT,
  input  logic                         IN_VALID,
  input  logic                         IN_LAST,
  output logic                         IN_READY,
  input  logic                         GO,
  output logic                         ARB_START,
  input  logic                         ARB_DONE,
  output logic [SRAM_ADDR_WIDTH-1:0]   SRAM_ADDR,
  output logic                         SRAM_CS,
  output logic                         SRAM_CLKEN,
  output logic                         SRAM_WR,
  output logic [SRAM_DAT_WIDTH-1:0]    SRAM_WR_DAT,
  output logic [SRAM_BYTEEN_WIDTH-1:0] SRAM_BYTEEN,
  output logic [SRAM_ADDR_WIDTH:0]     LINES,
  output logic                         BUSY,
  output logic                         ERR
);

  if (!widths_ok(WORD_WIDTH, SRAM_DAT_WIDTH, SRAM_BYTEEN_WIDTH)) begin : gen_width_check
    $error("nmr_bstrm_sram_loader: inconsistent WORD/DAT/BYTEEN widths");
  end

  loader_state_t              state_q, state_d;
  logic [SRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [SRAM_ADDR_WIDTH:0]   lines_q, lines_d;
  logic                       err_q, err_d;
  logic                       last_q, last_d;
  logic                       ready_int;
  logic                       accept;
  logic                       line_complete;
  logic                       ram_full;

  // GO beats a simultaneous word in READY.
  assign ready_int = (state_q == ST_IDLE) || (state_q == ST_LOAD) ||
                     ((state_q == ST_READY) && !GO);
  assign IN_READY  = ready_int && !RST;
  assign accept    = IN_VALID && IN_READY;

  // Top LINES bit set means every address has been written once.
  assign ram_full = lines_q[SRAM_ADDR_WIDTH];

  nmr_bstrm_word_packer #(
    .WORD_WIDTH (WORD_WIDTH),
    .DAT_WIDTH  (SRAM_DAT_WIDTH)
  ) u_packer (
    .clk           (CLK),
    .rst           (RST),
    .word          (IN_DAT),
    .accept        (accept),
    .last          (IN_LAST),
    .line_complete (line_complete),
    .line          (SRAM_WR_DAT)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    lines_d = lines_q;
    err_d   = err_q;
    last_d  = last_q;
    unique case (state_q)
      ST_IDLE, ST_READY: begin
        if ((state_q == ST_READY) && GO) begin
          state_d = ST_START;
        end else if (accept) begin
          // New program: restart from address 0.
          addr_d  = '0;
          lines_d = '0;
          err_d   = 1'b0;
          last_d  = IN_LAST;
          state_d = line_complete ? ST_WRITE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (line_complete) begin
          if (ram_full) begin
            // Overflow: drop the line, keep swallowing words until IN_LAST.
            err_d   = 1'b1;
            state_d = IN_LAST ? ST_READY : ST_LOAD;
          end else begin
            last_d  = IN_LAST;
            state_d = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        addr_d  = addr_q + SRAM_ADDR_WIDTH'(1);
        lines_d = lines_q + (SRAM_ADDR_WIDTH + 1)'(1);
        state_d = last_q ? ST_READY : ST_LOAD;
      end
      ST_START: state_d = ST_WAIT_LO;
      // Wait for DONE to drop first; the arbiter idles with DONE high.
      ST_WAIT_LO: if (!ARB_DONE) state_d = ST_WAIT_HI;
      ST_WAIT_HI: if (ARB_DONE) state_d = ST_READY;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      lines_q <= '0;
      err_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      lines_q <= lines_d;
      err_q   <= err_d;
      last_q  <= last_d;
    end
  end

  assign SRAM_CS     = (state_q == ST_WRITE);
  assign SRAM_CLKEN  = (state_q == ST_WRITE);
  assign SRAM_WR     = (state_q == ST_WRITE);
  assign SRAM_ADDR   = addr_q;
  assign SRAM_BYTEEN = '1;
  assign LINES       = lines_q;
  assign ERR         = err_q;
  assign ARB_START   = (state_q == ST_START);
  assign BUSY        = (state_q == ST_START) || (state_q == ST_WAIT_LO) ||
                       (state_q == ST_WAIT_HI);

endmodule

// File: tb/tb_nmr_bstrm_sram_loader.sv
// Directed bench for nmr_bstrm_sram_loader: a default-width instance for the
// packing/run/reset scenarios and a 2-bit-address instance for overflow.
module tb_nmr_bstrm_sram_loader;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  in_dat;
  logic         in_valid, in_last, in_ready, go, arb_start, arb_done;
  logic [7:0]   sram_addr;
  logic         sram_cs, sram_clken, sram_wr;
  logic [127:0] sram_wr_dat;
  logic [15:0]  sram_byteen;
  logic [8:0]   lines;
  logic         busy, err;

  logic [31:0]  o_in_dat;
  logic         o_in_valid, o_in_last, o_in_ready, o_go, o_arb_start, o_arb_done;
  logic [1:0]   o_sram_addr;
  logic         o_sram_cs, o_sram_clken, o_sram_wr;
  logic [127:0] o_sram_wr_dat;
  logic [15:0]  o_sram_byteen;
  logic [2:0]   o_lines;
  logic         o_busy, o_err;

  int n_total = 0;
  int n_pass  = 0;

  // Observation counters and captured writes (sampled mid-cycle).
  int acc_cnt = 0, rdy_low_cnt = 0, start_cnt = 0, busy_cnt = 0, wr_cnt = 0;
  int o_acc_cnt = 0, o_wr_cnt = 0;
  logic [127:0] mem   [4];
  logic [127:0] o_mem [4];

  always #5 clk = ~clk;

  nmr_bstrm_sram_loader dut (
    .CLK (clk), .RST (rst), .IN_DAT (in_dat), .IN_VALID (in_valid), .IN_LAST (in_last),
    .IN_READY (in_ready), .GO (go), .ARB_START (arb_start), .ARB_DONE (arb_done),
    .SRAM_ADDR (sram_addr), .SRAM_CS (sram_cs), .SRAM_CLKEN (sram_clken),
    .SRAM_WR (sram_wr), .SRAM_WR_DAT (sram_wr_dat), .SRAM_BYTEEN (sram_byteen),
    .LINES (lines), .BUSY (busy), .ERR (err)
  );

  nmr_bstrm_sram_loader #(.SRAM_ADDR_WIDTH (2)) dut_ovf (
    .CLK (clk), .RST (rst), .IN_DAT (o_in_dat), .IN_VALID (o_in_valid),
    .IN_LAST (o_in_last), .IN_READY (o_in_ready), .GO (o_go), .ARB_START (o_arb_start),
    .ARB_DONE (o_arb_done), .SRAM_ADDR (o_sram_addr), .SRAM_CS (o_sram_cs),
    .SRAM_CLKEN (o_sram_clken), .SRAM_WR (o_sram_wr), .SRAM_WR_DAT (o_sram_wr_dat),
    .SRAM_BYTEEN (o_sram_byteen), .LINES (o_lines), .BUSY (o_busy), .ERR (o_err)
  );

  always @(negedge clk) begin
    if (in_valid && in_ready) acc_cnt++;
    if (!in_ready) rdy_low_cnt++;
    if (arb_start) start_cnt++;
    if (busy) busy_cnt++;
    if (sram_cs && sram_clken && sram_wr) begin
      wr_cnt++;
      if (sram_addr < 8'd4) mem[sram_addr[1:0]] = sram_wr_dat;
    end
    if (o_in_valid && o_in_ready) o_acc_cnt++;
    if (o_sram_cs && o_sram_clken && o_sram_wr) begin
      o_wr_cnt++;
      o_mem[o_sram_addr] = o_sram_wr_dat;
    end
  end

  // Streams n consecutive words starting at 'first'; IN_VALID stays high.
  task automatic send_seq(input bit sel, input logic [31:0] first, input int n,
                          input bit with_last);
    int t;
    for (int i = 0; i < n; i++) begin
      if (sel) begin
        o_in_dat = first + 32'(i); o_in_valid = 1'b1; o_in_last = with_last && (i == n - 1);
      end else begin
        in_dat = first + 32'(i); in_valid = 1'b1; in_last = with_last && (i == n - 1);
      end
      t = 0;
      while (!(sel ? o_in_ready : in_ready) && t < 20) begin
        @(posedge clk); #1; t++;
      end
      if (t >= 20) begin
        n_total++;
        $display("FAIL send_timeout: word %0d not accepted within 20 cycles", i);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0; o_in_valid = 1'b0; o_in_last = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", in_ready);
    else n_pass++;
    n_total++;
    if ({arb_start, busy, err, sram_cs, sram_clken, sram_wr} !== 6'b0)
      $display("FAIL rst_strobes: got %b want 000000",
               {arb_start, busy, err, sram_cs, sram_clken, sram_wr});
    else n_pass++;
    n_total++;
    if (sram_addr !== 8'd0 || sram_wr_dat !== 128'd0 || lines !== 9'd0)
      $display("FAIL rst_regs: addr %h dat %h lines %0d want 0", sram_addr, sram_wr_dat, lines);
    else n_pass++;
    n_total++; if (sram_byteen !== 16'hffff) $display("FAIL rst_byteen: got %h want ffff",
                                                       sram_byteen);
    else n_pass++;
    n_total++; if (o_err !== 1'b0) $display("FAIL rst_ovf_err: got %b want 0", o_err);
    else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
    n_total++; if (in_ready !== 1'b1) $display("FAIL idle_in_ready: got %b want 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_pack8();
    int s_wr, s_low;
    s_wr = wr_cnt; s_low = rdy_low_cnt;
    send_seq(1'b0, 32'h1, 8, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (wr_cnt - s_wr !== 2) $display("FAIL pack8_writes: got %0d want 2",
                                                 wr_cnt - s_wr);
    else n_pass++;
    n_total++;
    if (mem[0] !== 128'h00000004_00000003_00000002_00000001)
      $display("FAIL pack8_line0: got %h want 00000004000000030000000200000001", mem[0]);
    else n_pass++;
    n_total++;
    if (mem[1] !== 128'h00000008_00000007_00000006_00000005)
      $display("FAIL pack8_line1: got %h want 00000008000000070000000600000005", mem[1]);
    else n_pass++;
    n_total++; if (lines !== 9'd2) $display("FAIL pack8_lines: got %0d want 2", lines);
    else n_pass++;
    n_total++; if (rdy_low_cnt - s_low !== 2)
      $display("FAIL pack8_bubbles: got %0d want 2", rdy_low_cnt - s_low);
    else n_pass++;
    n_total++; if (in_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL pack8_ready: in_ready %b busy %b want 1 0", in_ready, busy);
    else n_pass++;
  endtask

  task automatic test_partial();
    int s_wr;
    s_wr = wr_cnt;
    send_seq(1'b0, 32'hA, 5, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if (mem[0] !== 128'h0000000D_0000000C_0000000B_0000000A)
      $display("FAIL partial_line0: got %h want 0000000d0000000c0000000b0000000a", mem[0]);
    else n_pass++;
    n_total++;
    if (mem[1] !== 128'h0000000E)
      $display("FAIL partial_line1: got %h want 0000000e zero-filled", mem[1]);
    else n_pass++;
    n_total++; if (lines !== 9'd2) $display("FAIL partial_lines: got %0d want 2", lines);
    else n_pass++;
    n_total++; if (wr_cnt - s_wr !== 2) $display("FAIL partial_writes: got %0d want 2",
                                                 wr_cnt - s_wr);
    else n_pass++;
  endtask

  task automatic test_run();
    int s_start, s_busy, s_wr;
    s_start = start_cnt; s_busy = busy_cnt; s_wr = wr_cnt;
    go = 1'b1; arb_done = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    n_total++; if (arb_start !== 1'b1 || busy !== 1'b1)
      $display("FAIL run_start: arb_start %b busy %b want 1 1", arb_start, busy);
    else n_pass++;
    @(posedge clk); #1;
    n_total++; if (arb_start !== 1'b0 || busy !== 1'b1)
      $display("FAIL run_pulse: arb_start %b busy %b want 0 1", arb_start, busy);
    else n_pass++;
    @(posedge clk); #1;
    arb_done = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    arb_done = 1'b1;
    n_total++; if (busy !== 1'b1) $display("FAIL run_busy_hold: got %b want 1", busy);
    else n_pass++;
    @(posedge clk); #1;
    n_total++; if (busy !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL run_end: busy %b in_ready %b want 0 1", busy, in_ready);
    else n_pass++;
    n_total++; if (start_cnt - s_start !== 1)
      $display("FAIL run_start_count: got %0d want 1", start_cnt - s_start);
    else n_pass++;
    n_total++; if (busy_cnt - s_busy !== 13)
      $display("FAIL run_busy_cycles: got %0d want 13", busy_cnt - s_busy);
    else n_pass++;
    n_total++; if (wr_cnt - s_wr !== 0) $display("FAIL run_no_write: got %0d want 0",
                                                 wr_cnt - s_wr);
    else n_pass++;
  endtask

  task automatic test_overflow();
    int s_acc, s_wr;
    s_acc = o_acc_cnt; s_wr = o_wr_cnt;
    send_seq(1'b1, 32'h1, 20, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (o_err !== 1'b1) $display("FAIL ovf_err: got %b want 1", o_err);
    else n_pass++;
    n_total++; if (o_lines !== 3'd4) $display("FAIL ovf_lines: got %0d want 4", o_lines);
    else n_pass++;
    n_total++; if (o_wr_cnt - s_wr !== 4) $display("FAIL ovf_writes: got %0d want 4",
                                                   o_wr_cnt - s_wr);
    else n_pass++;
    n_total++; if (o_acc_cnt - s_acc !== 20) $display("FAIL ovf_accepted: got %0d want 20",
                                                      o_acc_cnt - s_acc);
    else n_pass++;
    n_total++;
    if (o_mem[0] !== 128'h00000004_00000003_00000002_00000001)
      $display("FAIL ovf_line0: got %h want 00000004000000030000000200000001", o_mem[0]);
    else n_pass++;
    n_total++;
    if (o_mem[3] !== 128'h00000010_0000000F_0000000E_0000000D)
      $display("FAIL ovf_line3: got %h want 000000100000000f0000000e0000000d", o_mem[3]);
    else n_pass++;
    n_total++; if (o_in_ready !== 1'b1) $display("FAIL ovf_ready: got %b want 1", o_in_ready);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    int s_wr;
    send_seq(1'b0, 32'h11, 6, 1'b0);
    n_total++; if (lines !== 9'd1) $display("FAIL mid_pre_lines: got %0d want 1", lines);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_total++;
    if (in_ready !== 1'b0 || lines !== 9'd0 || sram_addr !== 8'd0 || sram_wr_dat !== 128'd0)
      $display("FAIL mid_rst_regs: rdy %b lines %0d addr %h dat %h want 0", in_ready, lines,
               sram_addr, sram_wr_dat);
    else n_pass++;
    n_total++; if ({busy, err, sram_cs, sram_wr} !== 4'b0)
      $display("FAIL mid_rst_flags: got %b want 0000", {busy, err, sram_cs, sram_wr});
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    s_wr = wr_cnt;
    send_seq(1'b0, 32'h21, 4, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if (mem[0] !== 128'h00000024_00000023_00000022_00000021)
      $display("FAIL mid_line0: got %h want 00000024000000230000002200000021", mem[0]);
    else n_pass++;
    n_total++; if (lines !== 9'd1 || err !== 1'b0)
      $display("FAIL mid_lines_err: lines %0d err %b want 1 0", lines, err);
    else n_pass++;
    n_total++; if (wr_cnt - s_wr !== 1) $display("FAIL mid_writes: got %0d want 1",
                                                 wr_cnt - s_wr);
    else n_pass++;
  endtask

  task automatic test_go_vs_valid();
    int s_acc, t;
    s_acc = acc_cnt;
    go = 1'b1; in_valid = 1'b1; in_dat = 32'h55; in_last = 1'b1; arb_done = 1'b1;
    #1;
    n_total++; if (in_ready !== 1'b0) $display("FAIL gv_ready: got %b want 0", in_ready);
    else n_pass++;
    @(posedge clk); #1;
    go = 1'b0;
    n_total++; if (arb_start !== 1'b1) $display("FAIL gv_start: got %b want 1", arb_start);
    else n_pass++;
    arb_done = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    arb_done = 1'b1;
    n_total++; if (acc_cnt - s_acc !== 0) $display("FAIL gv_held: got %0d accepted want 0",
                                                   acc_cnt - s_acc);
    else n_pass++;
    t = 0;
    while (!in_ready && t < 20) begin @(posedge clk); #1; t++; end
    if (t >= 20) begin
      n_total++;
      $display("FAIL gv_timeout: no return to READY within 20 cycles");
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    @(posedge clk); #1;
    n_total++; if (acc_cnt - s_acc !== 1) $display("FAIL gv_accepted: got %0d want 1",
                                                   acc_cnt - s_acc);
    else n_pass++;
    n_total++; if (mem[0] !== 128'h55) $display("FAIL gv_line0: got %h want 00..0055", mem[0]);
    else n_pass++;
    n_total++; if (lines !== 9'd1) $display("FAIL gv_lines: got %0d want 1", lines);
    else n_pass++;
  endtask

  initial begin
    in_dat = '0; in_valid = 1'b0; in_last = 1'b0; go = 1'b0; arb_done = 1'b1;
    o_in_dat = '0; o_in_valid = 1'b0; o_in_last = 1'b0; o_go = 1'b0; o_arb_done = 1'b1;
    for (int i = 0; i < 4; i++) begin mem[i] = 'x; o_mem[i] = 'x; end
    @(negedge clk);
    test_reset();
    test_pack8();
    test_partial();
    test_run();
    test_overflow();
    test_mid_reset();
    test_go_vs_valid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
